// File: rtl/serial_sub_ctrl_pkg.sv
// Shared constants, FSM state type and index-width helper for serial_sub_ctrl.
package serial_sub_ctrl_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so a nibble index always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) w++;
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_bls4_sub.sv
// 4-bit borrow-lookahead subtractor: diff = x - y - bin, bout = borrow out of bit 3.
module bls4_sub
    import serial_sub_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] x_i,
    input  logic [NIB_W-1:0] y_i,
    input  logic             bin_i,
    output logic [NIB_W-1:0] diff_o,
    output logic             bout_o
);

    logic [NIB_W-1:0] gen;
    logic [NIB_W-1:0] prop;
    logic [NIB_W:0]   brw;

    // A bit generates a borrow when x=0,y=1 and passes one through when x==y.
    assign gen  = ~x_i & y_i;
    assign prop = ~(x_i ^ y_i);

    assign brw[0] = bin_i;
    assign brw[1] = gen[0] | (prop[0] & bin_i);
    assign brw[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & bin_i);
    assign brw[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                  | (prop[2] & prop[1] & prop[0] & bin_i);
    assign brw[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                  | (prop[3] & prop[2] & prop[1] & gen[0])
                  | (prop[3] & prop[2] & prop[1] & prop[0] & bin_i);

    assign diff_o = x_i ^ y_i ^ brw[NIB_W-1:0];
    assign bout_o = brw[NIB_W];

endmodule

// File: rtl/serial_sub_ctrl.sv
// Nibble-serial subtractor: diff = a - b - bin over WORD_W/4 cycles using one bls4_sub.
// Define SERIAL_SUB_OVF_EN to enable the signed-overflow flag; otherwise ovf is tied 0.
module serial_sub_ctrl
    import serial_sub_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              bin,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] diff,
    output logic              bout,
    output logic              zero,
    output logic              ovf
);

    localparam int unsigned      NIBS  = WORD_W / NIB_W;
    localparam int unsigned      IDX_W = clog2(NIBS);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NIBS - 1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              brw_q, brw_d;
    logic [WORD_W-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic              bout_q, bout_d, zero_q, zero_d;
    logic [NIB_W-1:0]  nib_x, nib_y, nib_diff;
    logic              nib_bout;

    assign nib_x = a_q[idx_q*NIB_W +: NIB_W];
    assign nib_y = b_q[idx_q*NIB_W +: NIB_W];

    bls4_sub u_bls4_sub (
        .x_i    (nib_x),
        .y_i    (nib_y),
        .bin_i  (brw_q),
        .diff_o (nib_diff),
        .bout_o (nib_bout)
    );

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        brw_d   = brw_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = bin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[idx_q*NIB_W +: NIB_W] = nib_diff;
                brw_d = nib_bout;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    // Flags are taken from the merged word so they are valid on entry to DONE.
                    bout_d  = nib_bout;
                    zero_d  = (diff_d == '0);
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (a_q[WORD_W-1] ^ b_q[WORD_W-1]) & (a_q[WORD_W-1] ^ diff_d[WORD_W-1]);
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            brw_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            brw_q   <= brw_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl (WORD_W=16) against an arithmetic reference model.
module tb_serial_sub_ctrl;

    logic        clk, rst, start, bin;
    logic [15:0] a, b;
    logic        busy, done, bout, zero, ovf;
    logic [15:0] diff;

    int total = 0;
    int bad   = 0;

    // results of the most recent operation
    logic [15:0] r_diff;
    logic        r_bout, r_zero, r_ovf, r_busy0;
    int          r_lat, r_pulses, r_overlap;

    serial_sub_ctrl #(.WORD_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .zero  (zero),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] m_diff(input logic [15:0] x, y, input logic c);
        int r;
        r = int'(x) - int'(y) - int'(c);
        return 16'(r & 32'hFFFF);
    endfunction

    function automatic logic m_bout(input logic [15:0] x, y, input logic c);
        return (int'(x) < int'(y) + int'(c));
    endfunction

    function automatic logic m_ovf(input logic [15:0] x, y, input logic c);
        int s;
        s = int'($signed(x)) - int'($signed(y)) - int'(c);
`ifdef SERIAL_SUB_OVF_EN
        return (s > 32767) || (s < -32768);
`else
        return (s > 32767) && 1'b0;
`endif
    endfunction

    // Drive one operation; optionally re-assert start with junk operands while RUN/DONE.
    task automatic do_op(input logic [15:0] ia, ib, input logic ibin, input bit noise);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; bin = ibin;
        @(posedge clk); #1;
        r_busy0 = busy;
        start = 1'b0; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
        r_lat = -1; r_pulses = 0; r_overlap = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (busy && done) r_overlap++;
            if (done) begin
                r_pulses++;
                if (r_lat < 0) begin
                    r_lat  = k;
                    r_diff = diff; r_bout = bout; r_zero = zero; r_ovf = ovf;
                end
            end
            if (noise && k <= 4) begin
                start = 1'b1; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({busy, done, bout, zero, ovf} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=00000", {busy, done, bout, zero, ovf});
        end
        total++; if (diff !== 16'h0000) begin
            bad++; $display("FAIL reset_diff got=%h exp=0000", diff);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [15:0] ta [4] = '{16'h1234, 16'h0000, 16'h0005, 16'hABCD};
        logic [15:0] tb [4] = '{16'h0234, 16'h0001, 16'h0005, 16'hABCD};
        logic        tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] ed [4] = '{16'h1000, 16'hFFFF, 16'hFFFF, 16'h0000};
        logic        eb [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic        ez [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            do_op(ta[i], tb[i], tc[i], 1'b0);
            total++; if (r_diff !== ed[i]) begin
                bad++; $display("FAIL dir%0d_diff got=%h exp=%h", i, r_diff, ed[i]);
            end
            total++; if (r_bout !== eb[i]) begin
                bad++; $display("FAIL dir%0d_bout got=%b exp=%b", i, r_bout, eb[i]);
            end
            total++; if (r_zero !== ez[i]) begin
                bad++; $display("FAIL dir%0d_zero got=%b exp=%b", i, r_zero, ez[i]);
            end
            // done is seen 4 edges after the accepting edge, i.e. on the 5th edge counting it
            total++; if (r_lat !== 4) begin
                bad++; $display("FAIL dir%0d_latency got=%0d exp=4", i, r_lat);
            end
            total++; if (r_pulses !== 1 || r_overlap !== 0 || r_busy0 !== 1'b1) begin
                bad++; $display("FAIL dir%0d_handshake got=pulses%0d/overlap%0d/busy%b exp=1/0/1",
                                i, r_pulses, r_overlap, r_busy0);
            end
        end
    endtask

    task automatic test_ovf;
        logic [15:0] ta [2] = '{16'h8000, 16'h7FFF};
        logic [15:0] tb [2] = '{16'h0001, 16'hFFFF};
        logic [15:0] ed [2] = '{16'h7FFF, 16'h8000};
        logic        eo;
`ifdef SERIAL_SUB_OVF_EN
        eo = 1'b1;
`else
        eo = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            do_op(ta[i], tb[i], 1'b0, 1'b0);
            total++; if (r_diff !== ed[i]) begin
                bad++; $display("FAIL ovf%0d_diff got=%h exp=%h", i, r_diff, ed[i]);
            end
            total++; if (r_ovf !== eo) begin
                bad++; $display("FAIL ovf%0d_flag got=%b exp=%b", i, r_ovf, eo);
            end
        end
    endtask

    task automatic test_random;
        logic [15:0] xa, xb;
        logic        xc;
        for (int i = 0; i < 30; i++) begin
            xa = 16'($urandom); xb = 16'($urandom); xc = 1'($urandom);
            if (i % 5 == 0) xb = xa;
            do_op(xa, xb, xc, 1'b0);
            total++;
            if (r_lat !== 4 || r_diff !== m_diff(xa, xb, xc) || r_bout !== m_bout(xa, xb, xc)
                || r_zero !== (m_diff(xa, xb, xc) == 16'h0) || r_ovf !== m_ovf(xa, xb, xc)) begin
                bad++;
                $display("FAIL rand%0d a=%h b=%h bin=%b got=%h/%b/%b/%b lat%0d exp=%h/%b/%b/%b lat4",
                         i, xa, xb, xc, r_diff, r_bout, r_zero, r_ovf, r_lat,
                         m_diff(xa, xb, xc), m_bout(xa, xb, xc),
                         m_diff(xa, xb, xc) == 16'h0, m_ovf(xa, xb, xc));
            end
        end
    endtask

    task automatic test_ignore_start;
        do_op(16'h4321, 16'h1111, 1'b1, 1'b1);
        total++; if (r_diff !== 16'h320F || r_bout !== 1'b0) begin
            bad++; $display("FAIL ignore_result got=%h/%b exp=320f/0", r_diff, r_bout);
        end
        total++; if (r_pulses !== 1 || r_lat !== 4) begin
            bad++; $display("FAIL ignore_pulses got=%0d/lat%0d exp=1/lat4", r_pulses, r_lat);
        end
    endtask

    task automatic test_idle_hold;
        int errs;
        do_op(16'h0100, 16'h0200, 1'b0, 1'b0);
        errs = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
            if (diff !== 16'hFF00 || bout !== 1'b1 || zero !== 1'b0 || busy || done) errs++;
        end
        total++; if (errs !== 0) begin
            bad++; $display("FAIL idle_hold got=%0d_bad_cycles exp=0 (diff=%h bout=%b)", errs, diff, bout);
        end
    endtask

    task automatic test_reset_mid_run;
        int pulses;
        @(negedge clk);
        start = 1'b1; a = 16'h9999; b = 16'h1234; bin = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if ({busy, done, bout, zero, ovf} !== 5'b0 || diff !== 16'h0) begin
            bad++; $display("FAIL midrun_reset got=%b/%h exp=00000/0000", {busy, done, bout, zero, ovf}, diff);
        end
        pulses = 0;
        repeat (3) begin @(posedge clk); #1; if (done) pulses++; end
        @(negedge clk); rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; if (done || busy) pulses++; end
        total++; if (pulses !== 0) begin
            bad++; $display("FAIL midrun_no_done got=%0d exp=0", pulses);
        end
        do_op(16'h0010, 16'h0001, 1'b0, 1'b0);
        total++; if (r_diff !== 16'h000F || r_lat !== 4) begin
            bad++; $display("FAIL midrun_restart got=%h/lat%0d exp=000f/lat4", r_diff, r_lat);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ovf;
        test_random;
        test_ignore_start;
        test_idle_hold;
        test_reset_mid_run;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
